// File: rtl/widen_shl_pkg.sv
// Shared fixed-point definitions for the Q15 -> Q31 widening/shift block.
package widen_shl_pkg;

  typedef enum logic [1:0] {
    MODE_DEPOSIT_L     = 2'b00,
    MODE_DEPOSIT_H     = 2'b01,
    MODE_SHL_SAT       = 2'b10,
    MODE_DEPOSIT_H_SHR = 2'b11
  } mode_e;

  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;
  localparam int          STAGES = 2;

  typedef struct packed {
    logic signed [15:0] din;
    mode_e              mode;
    logic [4:0]         shift;
  } s1_req_t;

  typedef struct packed {
    logic [31:0] res;
    logic        sat;
  } s2_rsp_t;

endpackage

// File: rtl/widen_shl_shl_sat32.sv
// Saturating left shift of a Q15 sample into a Q31 result.
module shl_sat32
  import widen_shl_pkg::*;
(
  input  logic signed [15:0] in,
  input  logic [4:0]         shift,
  output logic [31:0]        out,
  output logic               sat
);

  logic [46:0] wide;
  logic        ovf;

  // 16 + 31 bits holds every possible shift exactly; fits in 32 iff bits 46..31 agree
  assign wide = {{31{in[15]}}, in} << shift;
  assign ovf  = (wide[46:31] != {16{wide[31]}});

  always_comb begin
    sat = ovf;
    out = wide[31:0];
    if (ovf) out = wide[46] ? MIN_32 : MAX_32;
  end

endmodule

// File: rtl/widen_shl.sv
// Two-stage ready/valid pipeline widening Q15 to Q31 with deposit, shift and saturation.
module widen_shl
  import widen_shl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in,
  input  logic [1:0]         mode,
  input  logic [4:0]         shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out,
  output logic               sat,
  output logic [15:0]        sat_count,
  input  logic               clear_count
);

  logic [STAGES:1] vld_pipe;
  logic            s1_en, s2_en;
  s1_req_t         s1;
  s2_rsp_t         s2, rsp_d;
  logic [31:0]     shl_out;
  logic            shl_sat;

  assign s2_en     = !vld_pipe[2] || out_ready;
  assign s1_en     = !vld_pipe[1] || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = vld_pipe[2];
  assign out       = s2.res;
  assign sat       = s2.sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else begin
      if (s1_en) vld_pipe[1] <= in_valid;
      if (s2_en) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Operand register carries no reset: its contents are qualified by vld_pipe[1]
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) s1 <= '{din: in, mode: mode_e'(mode), shift: shift};
  end

  shl_sat32 u_shl (
    .in    (s1.din),
    .shift (s1.shift),
    .out   (shl_out),
    .sat   (shl_sat)
  );

  always_comb begin
    rsp_d = '0;
    case (s1.mode)
      MODE_DEPOSIT_L:     rsp_d.res = {{16{s1.din[15]}}, s1.din};
      MODE_DEPOSIT_H:     rsp_d.res = {s1.din, 16'h0000};
      MODE_SHL_SAT:       rsp_d = '{res: shl_out, sat: shl_sat};
      MODE_DEPOSIT_H_SHR: rsp_d.res = $signed({s1.din, 16'h0000}) >>> s1.shift;
      default:            rsp_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s2 <= '0;
    else if (s2_en && vld_pipe[1]) s2 <= rsp_d;
  end

  // Clear wins over a coincident increment; counter sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_count <= '0;
    else if (clear_count) sat_count <= '0;
    else if (out_valid && out_ready && sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_widen_shl.sv
// Self-checking bench for widen_shl: directed corner cases plus a randomized scoreboard.
module tb_widen_shl;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready;
  logic signed [15:0] din;
  logic [1:0]         mode;
  logic [4:0]         shift;
  logic               out_valid, out_ready;
  logic signed [31:0] out;
  logic               sat;
  logic [15:0]        sat_count;
  logic               clear_count;

  widen_shl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .mode(mode), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .sat(sat), .sat_count(sat_count),
    .clear_count(clear_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic        s;
  } exp_t;

  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   n_xfer = 0;
  exp_t exp_q[$];

  function automatic exp_t ref_model(logic signed [15:0] a, logic [1:0] m, logic [4:0] sh);
    longint x, r;
    exp_t   e;
    x = longint'(a);
    e.s = 1'b0;
    case (m)
      2'd0: r = x;
      2'd1: r = x * 65536;
      2'd2: begin
        r = x * (longint'(1) << sh);
        if (r > LMAX) begin r = LMAX; e.s = 1'b1; end
        else if (r < LMIN) begin r = LMIN; e.s = 1'b1; end
      end
      default: r = (x * 65536) >>> sh;
    endcase
    e.o = r[31:0];
    return e;
  endfunction

  // One clock: scoreboard any output transfer, queue any accept, check counter after the edge.
  task automatic cycle(output bit acc);
    exp_t e;
    bit   xs;
    @(negedge clk);
    acc = in_valid && in_ready;
    xs  = 1'b0;
    if (out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got out=%h sat=%b with empty queue", out, sat);
      end else begin
        e = exp_q.pop_front();
        xs = e.s;
        n_xfer++;
        if (out !== e.o || sat !== e.s) begin
          bad++;
          $display("FAIL sb_data got out=%h sat=%b want out=%h sat=%b", out, sat, e.o, e.s);
        end
      end
    end
    if (clear_count) exp_cnt = 0;
    else if (xs && exp_cnt < 65535) exp_cnt++;
    if (acc) exp_q.push_back(ref_model(din, mode, shift));
    @(posedge clk); #1;
    total++;
    if (sat_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL sat_count got %h want %h", sat_count, 16'(exp_cnt));
    end
  endtask

  // Push one sample and step until its result sits on out (out_ready high).
  task automatic launch(input logic [15:0] a, input logic [1:0] m, input logic [4:0] sh);
    bit acc;
    din = a; mode = m; shift = sh; in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_count = 1'b0;
    din = '0; mode = '0; shift = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out !== 32'h0)      begin bad++; $display("FAIL rst_out got %h want 0", out); end
    if (sat !== 1'b0)       begin bad++; $display("FAIL rst_sat got %b want 0", sat); end
    if (sat_count !== 16'h0) begin bad++; $display("FAIL rst_sat_count got %h want 0", sat_count); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mode00();
    bit acc;
    din = 16'hFFFE; mode = 2'b00; shift = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    total += 2;
    if (acc !== 1'b1) begin bad++; $display("FAIL m00_accept got %b want 1", acc); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL m00_early_valid got %b want 0", out_valid); end
    cycle(acc);
    total++;
    if (out_valid !== 1'b1 || out !== 32'hFFFF_FFFE || sat !== 1'b0) begin
      bad++;
      $display("FAIL m00_result got v=%b out=%h sat=%b want v=1 out=fffffffe sat=0", out_valid, out, sat);
    end
    cycle(acc);
  endtask

  task automatic test_shl_sat();
    bit acc;
    launch(16'h4000, 2'b10, 5'd16);
    total++;
    if (out !== 32'h4000_0000 || sat !== 1'b0) begin
      bad++; $display("FAIL shl16 got out=%h sat=%b want 40000000/0", out, sat);
    end
    cycle(acc);
    launch(16'h4000, 2'b10, 5'd17);
    total++;
    if (out !== 32'h7FFF_FFFF || sat !== 1'b1) begin
      bad++; $display("FAIL shl17 got out=%h sat=%b want 7fffffff/1", out, sat);
    end
    cycle(acc);
    total++;
    if (sat_count !== 16'd1) begin bad++; $display("FAIL shl17_count got %h want 1", sat_count); end
  endtask

  task automatic test_shl_neg();
    bit acc;
    launch(16'hC000, 2'b10, 5'd18);
    total++;
    if (out !== 32'h8000_0000 || sat !== 1'b1) begin
      bad++; $display("FAIL neg_sat got out=%h sat=%b want 80000000/1", out, sat);
    end
    cycle(acc);
    launch(16'h8000, 2'b10, 5'd16);
    total++;
    if (out !== 32'h8000_0000 || sat !== 1'b0) begin
      bad++; $display("FAIL min_exact got out=%h sat=%b want 80000000/0", out, sat);
    end
    cycle(acc);
    launch(16'h0000, 2'b10, 5'd31);
    total++;
    if (out !== 32'h0 || sat !== 1'b0) begin
      bad++; $display("FAIL zero_shl got out=%h sat=%b want 0/0", out, sat);
    end
    cycle(acc);
    launch(16'h8000, 2'b11, 5'd4);
    total++;
    if (out !== 32'hF800_0000 || sat !== 1'b0) begin
      bad++; $display("FAIL shr4 got out=%h sat=%b want f8000000/0", out, sat);
    end
    cycle(acc);
  endtask

  task automatic test_back_to_back();
    bit          acc, saw_full;
    int          idx, start;
    logic [31:0] held;
    logic [15:0] vals[8];
    foreach (vals[i]) vals[i] = 16'($urandom);
    idx = 0; start = n_xfer; saw_full = 1'b0; held = '0;
    mode = 2'b01; shift = 5'd0;
    for (int c = 0; c < 60 && (n_xfer - start) < 8; c++) begin
      out_ready = !(c >= 3 && c < 6);
      in_valid = (idx < 8);
      if (idx < 8) din = vals[idx];
      if (c == 3) held = out;
      cycle(acc);
      if (acc) idx++;
      if (c >= 3 && c < 6) begin
        total++;
        if (out !== held || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_stall_stable got out=%h v=%b want out=%h v=1", out, out_valid, held);
        end
        if (!in_ready) saw_full = 1'b1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total += 2;
    if (saw_full !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got never-low want low while full"); end
    if (n_xfer - start != 8 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count got %0d outputs (%0d queued) want 8 (0)", n_xfer - start, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      clear_count = ($urandom_range(0, 49) == 0);
      din   = 16'($urandom);
      mode  = 2'($urandom);
      shift = 5'($urandom);
      cycle(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
    repeat (4) cycle(acc);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_flight();
    bit acc;
    exp_t e;
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00; shift = 5'd0;
    din = 16'h1234; cycle(acc);
    din = 16'h5678; cycle(acc);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rflt_out_valid got %b want 0", out_valid); end
    if (out !== 32'h0)      begin bad++; $display("FAIL rflt_out got %h want 0", out); end
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rflt_in_ready got %b want 1", in_ready); end
    if (sat_count !== 16'h0) begin bad++; $display("FAIL rflt_count got %h want 0", sat_count); end
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    din = 16'h8001; mode = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rflt_stale got v=%b out=%h want v=0", out_valid, out); end
    cycle(acc);
    e = ref_model(16'h8001, 2'b01, 5'd0);
    total++;
    if (out_valid !== 1'b1 || out !== e.o) begin
      bad++; $display("FAIL rflt_first got v=%b out=%h want v=1 out=%h", out_valid, out, e.o);
    end
    cycle(acc);
  endtask

  task automatic test_sat_count();
    bit acc;
    int start, n0;
    din = 16'h4000; mode = 2'b10; shift = 5'd17; in_valid = 1'b1; out_ready = 1'b1;
    start = n_xfer;
    for (int c = 0; c < 70000 && (n_xfer - start) < 65536; c++) cycle(acc);
    total++;
    if (sat_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_hold got %h want ffff", sat_count); end
    clear_count = 1'b1;
    n0 = n_xfer;
    cycle(acc);
    clear_count = 1'b0;
    total += 2;
    if (n_xfer != n0 + 1) begin bad++; $display("FAIL cnt_clr_xfer got %0d transfers want 1", n_xfer - n0); end
    if (sat_count !== 16'h0) begin bad++; $display("FAIL cnt_clear got %h want 0", sat_count); end
    in_valid = 1'b0;
    repeat (3) cycle(acc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mode00();
    test_shl_sat();
    test_shl_neg();
    test_back_to_back();
    test_random();
    test_reset_flight();
    test_sat_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/widen_shl.md
WIDEN_SHL -- requirements
Module: widen_shl

Interface
REQ-001 SHALL have clock clk, input, 1 bit; rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1 bit; asynchronous, active-high reset.
REQ-003 SHALL have in_valid, input, 1 bit; input sample present.
REQ-004 SHALL have in_ready, output, 1 bit; block can accept a sample this cycle.
REQ-005 SHALL have in, input, 16 bits signed; Q15 operand.
REQ-006 SHALL have mode, input, 2 bits; operation select, sampled with in.
REQ-007 SHALL have shift, input, 5 bits unsigned; shift amount 0..31, sampled with in.
REQ-008 SHALL have out_valid, output, 1 bit; result present.
REQ-009 SHALL have out_ready, input, 1 bit; downstream accepts result.
REQ-010 SHALL have out, output, 32 bits signed; Q31 result.
REQ-011 SHALL have sat, output, 1 bit; current result was clipped.
REQ-012 SHALL have sat_count, output, 16 bits; count of saturated results transferred.
REQ-013 SHALL have clear_count, input, 1 bit; synchronous clear of sat_count.

Function
REQ-014 SHALL transfer input on in_valid&in_ready and output on out_valid&out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers in/mode/shift, S2 registers out/sat.
REQ-016 SHALL have latency 2 cycles from input transfer to out_valid, with out_ready held high.
REQ-017 SHALL sustain 1 sample/cycle with out_ready held high.
REQ-018 S2 load enable SHALL be !s2_valid | out_ready.
REQ-019 S1 load enable SHALL be !s1_valid | S2 load enable.
REQ-020 in_ready SHALL equal S1 load enable, combinationally.
REQ-021 out and sat SHALL hold stable while out_valid=1 and out_ready=0; no sample is lost or duplicated.
REQ-022 mode 00 SHALL produce sign_extend(in); sat=0.
REQ-023 mode 01 SHALL produce in<<16, low half zero; sat=0.
REQ-024 mode 10 SHALL produce sign_extend(in)<<shift, computed at 47-bit width.
REQ-025 In mode 10, a result >2^31-1 SHALL become 0x7FFFFFFF with sat=1, and a result <-2^31 SHALL become 0x80000000 with sat=1.
REQ-026 mode 11 SHALL produce (in<<16)>>>shift, arithmetic, sign-filled; sat=0.
REQ-027 Mode 10 boundaries SHALL be: in=0x8000, shift=16 gives 0x80000000, sat=0; in=0 gives 0, sat=0 for any shift.
REQ-028 sat_count SHALL increment on an output transfer with sat=1 and hold at 0xFFFF.
REQ-029 clear_count SHALL have priority over a simultaneous increment; the result is 0.
REQ-030 sat_count SHALL count only transferred results; stalled results SHALL NOT be recounted.

Reset
REQ-031 While reset is asserted: s1_valid=0, s2_valid=0, out_valid=0, out=0, sat=0, sat_count=0, in_ready=1.
REQ-032 Reset mid-operation SHALL discard all in-flight samples; the first accept after release SHALL follow REQ-016.
REQ-033 Reset SHALL reach no datapath input; in, mode and shift are don't-care during reset.

Structure
REQ-034 A shared fixed-point package SHALL hold MODE_DEPOSIT_L=00, MODE_DEPOSIT_H=01, MODE_SHL_SAT=10, MODE_DEPOSIT_H_SHR=11, MAX_32=0x7FFFFFFF and MIN_32=0x80000000.
REQ-035 A combinational sub-module shl_sat32 SHALL compute the mode 10 result and sat flag; widen_shl SHALL instantiate it between S1 and S2.

Verification
REQ-036 Bench SHALL cover: mode 00, in=0xFFFE -> out=0xFFFFFFFE, sat=0, 2 cycles after accept.
REQ-037 Bench SHALL cover: mode 10, in=0x4000, shift=16 -> 0x40000000, sat=0; shift=17 -> 0x7FFFFFFF, sat=1, sat_count=1.
REQ-038 Bench SHALL cover: mode 10, in=0xC000, shift=18 -> 0x80000000, sat=1; mode 11, in=0x8000, shift=4 -> 0xF8000000, sat=0.
REQ-039 Bench SHALL cover: 8 back-to-back samples, out_ready=0 for 3 cycles mid-stream -> in_ready=0 once both stages are full, all 8 outputs in order, out stable while stalled.
REQ-040 Bench SHALL cover: 0x10000 saturating transfers, then clear_count coincident with a saturating transfer -> sat_count holds 0xFFFF, then becomes 0.
REQ-041 Bench SHALL cover: reset asserted with 2 samples in flight -> out_valid=0 and out=0 immediately, no stale output after release.
